// File: rtl/id_ex_pipeline_reg_if.sv
// ID/EX stage bundle: ID-side fields in, registered EX-side fields out.
// master = ID stage / driver, slave = the pipeline register itself.
interface id_ex_pipeline_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [1:0]        ALUOp;
    logic              RegDst;
    logic              RegWrite;
    logic              ALUSrc;
    logic              MemWrite;
    logic              MemRead;
    logic              MemtoReg;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;

    logic [1:0]        ALUOp_EX;
    logic              RegDst_EX;
    logic              RegWrite_EX;
    logic              ALUSrc_EX;
    logic              MemWrite_EX;
    logic              MemRead_EX;
    logic              MemtoReg_EX;
    logic [DATA_W-1:0] read_data1_EX;
    logic [DATA_W-1:0] read_data2_EX;
    logic [DATA_W-1:0] imm_ext_EX;
    logic [4:0]        rs_EX;
    logic [4:0]        rt_EX;
    logic [4:0]        rd_EX;
    logic [5:0]        funct_EX;
    logic              valid_EX;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output stall, flush, id_valid, ALUOp, RegDst, RegWrite, ALUSrc, MemWrite, MemRead,
               MemtoReg, read_data1, read_data2, imm_ext, rs, rt, rd, funct,
        input  ALUOp_EX, RegDst_EX, RegWrite_EX, ALUSrc_EX, MemWrite_EX, MemRead_EX,
               MemtoReg_EX, read_data1_EX, read_data2_EX, imm_ext_EX, rs_EX, rt_EX, rd_EX,
               funct_EX, valid_EX, bubble_count
    );

    modport slave (
        input  stall, flush, id_valid, ALUOp, RegDst, RegWrite, ALUSrc, MemWrite, MemRead,
               MemtoReg, read_data1, read_data2, imm_ext, rs, rt, rd, funct,
        output ALUOp_EX, RegDst_EX, RegWrite_EX, ALUSrc_EX, MemWrite_EX, MemRead_EX,
               MemtoReg_EX, read_data1_EX, read_data2_EX, imm_ext_EX, rs_EX, rt_EX, rd_EX,
               funct_EX, valid_EX, bubble_count
    );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with stall hold, flush bubble insertion and a
// saturating count of bubbles entering EX.
module id_ex_pipeline_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input logic                    clk,
    input logic                    rst,
    id_ex_pipeline_reg_if.slave    bus
);

    typedef struct packed {
        logic [1:0]        alu_op;
        logic              reg_dst;
        logic              reg_write;
        logic              alu_src;
        logic              mem_write;
        logic              mem_read;
        logic              mem_to_reg;
        logic [DATA_W-1:0] read_data1;
        logic [DATA_W-1:0] read_data2;
        logic [DATA_W-1:0] imm_ext;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [5:0]        funct;
        logic              valid;
    } stage_t;

    stage_t           stage_d, stage_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             no_side_effect;
    logic             load_bubble;
    logic             count_inc;

    // Hazard mux bubbles arrive with id_valid=1 but no side-effecting control.
    assign no_side_effect = ~(bus.RegWrite | bus.MemWrite | bus.MemRead) &
                            (bus.ALUOp == 2'b00);
    assign load_bubble    = ~bus.id_valid | no_side_effect;

    always_comb begin
        stage_d   = stage_q;
        count_inc = 1'b0;
        if (bus.flush) begin
            stage_d   = '0;
            count_inc = 1'b1;
        end else if (!bus.stall) begin
            stage_d.alu_op     = bus.ALUOp;
            stage_d.reg_dst    = bus.RegDst;
            stage_d.reg_write  = bus.RegWrite;
            stage_d.alu_src    = bus.ALUSrc;
            stage_d.mem_write  = bus.MemWrite;
            stage_d.mem_read   = bus.MemRead;
            stage_d.mem_to_reg = bus.MemtoReg;
            stage_d.read_data1 = bus.read_data1;
            stage_d.read_data2 = bus.read_data2;
            stage_d.imm_ext    = bus.imm_ext;
            stage_d.rs         = bus.rs;
            stage_d.rt         = bus.rt;
            stage_d.rd         = bus.rd;
            stage_d.funct      = bus.funct;
            stage_d.valid      = ~load_bubble;
            if (!bus.id_valid) begin
                stage_d.alu_op     = 2'b00;
                stage_d.reg_dst    = 1'b0;
                stage_d.reg_write  = 1'b0;
                stage_d.alu_src    = 1'b0;
                stage_d.mem_write  = 1'b0;
                stage_d.mem_read   = 1'b0;
                stage_d.mem_to_reg = 1'b0;
            end
            count_inc = load_bubble;
        end
    end

    always_comb begin
        count_d = count_q;
        if (count_inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            count_q <= '0;
        end else begin
            stage_q <= stage_d;
            count_q <= count_d;
        end
    end

    assign bus.ALUOp_EX      = stage_q.alu_op;
    assign bus.RegDst_EX     = stage_q.reg_dst;
    assign bus.RegWrite_EX   = stage_q.reg_write;
    assign bus.ALUSrc_EX     = stage_q.alu_src;
    assign bus.MemWrite_EX   = stage_q.mem_write;
    assign bus.MemRead_EX    = stage_q.mem_read;
    assign bus.MemtoReg_EX   = stage_q.mem_to_reg;
    assign bus.read_data1_EX = stage_q.read_data1;
    assign bus.read_data2_EX = stage_q.read_data2;
    assign bus.imm_ext_EX    = stage_q.imm_ext;
    assign bus.rs_EX         = stage_q.rs;
    assign bus.rt_EX         = stage_q.rt;
    assign bus.rd_EX         = stage_q.rd;
    assign bus.funct_EX      = stage_q.funct;
    assign bus.valid_EX      = stage_q.valid;
    assign bus.bubble_count  = count_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Randomized bench for id_ex_pipeline_reg against a cycle-level behavioural model.
module tb_id_ex_pipeline_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    id_ex_pipeline_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_pipeline_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected EX-side state; ctrl packs {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemtoReg}.
    logic [1:0]  m_alu_op;
    logic [5:0]  m_ctrl;
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [5:0]  m_funct;
    logic        m_valid;
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] in_ctrl();
        return {bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.MemWrite, bus.MemRead, bus.MemtoReg};
    endfunction

    task automatic model_edge();
        logic is_bubble;
        if (rst) begin
            {m_alu_op, m_ctrl, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd, m_funct, m_valid} = '0;
            m_cnt = 0;
        end else if (bus.flush) begin
            {m_alu_op, m_ctrl, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd, m_funct, m_valid} = '0;
            m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else if (!bus.stall) begin
            is_bubble = !bus.id_valid ||
                        (!bus.RegWrite && !bus.MemWrite && !bus.MemRead && bus.ALUOp == 0);
            m_alu_op = bus.id_valid ? bus.ALUOp : 2'b00;
            m_ctrl   = bus.id_valid ? in_ctrl() : 6'b0;
            m_rd1    = bus.read_data1;
            m_rd2    = bus.read_data2;
            m_imm    = bus.imm_ext;
            m_rs     = bus.rs;
            m_rt     = bus.rt;
            m_rd     = bus.rd;
            m_funct  = bus.funct;
            m_valid  = !is_bubble;
            if (is_bubble) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
    endtask

    task automatic compare_all();
        check("ctrl", {bus.ALUOp_EX, bus.RegDst_EX, bus.RegWrite_EX, bus.ALUSrc_EX,
                       bus.MemWrite_EX, bus.MemRead_EX, bus.MemtoReg_EX}, {m_alu_op, m_ctrl});
        check("rd1", bus.read_data1_EX, m_rd1);
        check("rd2", bus.read_data2_EX, m_rd2);
        check("imm", bus.imm_ext_EX, m_imm);
        check("regs", {bus.rs_EX, bus.rt_EX, bus.rd_EX, bus.funct_EX},
              {m_rs, m_rt, m_rd, m_funct});
        check("valid", bus.valid_EX, m_valid);
        check("count", bus.bubble_count, m_cnt[CNT_W-1:0]);
    endtask

    // Model the edge from the inputs held stable now, then compare just after it.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic valid, input logic [1:0] alu_op, input logic [5:0] ctrl,
                          input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [5:0] funct);
        bus.id_valid   = valid;
        bus.ALUOp      = alu_op;
        {bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.MemWrite, bus.MemRead, bus.MemtoReg} = ctrl;
        bus.read_data1 = rd1;
        bus.read_data2 = rd2;
        bus.imm_ext    = imm;
        bus.rs         = rs;
        bus.rt         = rt;
        bus.rd         = rd;
        bus.funct      = funct;
    endtask

    task automatic rand_in();
        logic [5:0] ctrl;
        logic [1:0] op;
        ctrl = 6'($urandom);
        op   = 2'($urandom);
        if ($urandom_range(0, 99) < 15) begin
            ctrl = ctrl & 6'b101001;  // keep only non-side-effecting bits
            op   = 2'b00;
        end
        set_in($urandom_range(0, 99) < 80, op, ctrl, $urandom, $urandom, $urandom,
               5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_cnt     = 0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // Reset held two cycles with nonzero inputs
        rst = 1'b1;
        set_in(1'b1, 2'b11, 6'b111111, 32'hFFFF_FFFF, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 6'd4);
        tick();
        tick();
        check("rst_valid", bus.valid_EX, 1'b0);
        check("rst_cnt", bus.bubble_count, '0);
        rst = 1'b0;

        // Normal load
        set_in(1'b1, 2'b10, 6'b110000, 32'h1234_5678, 32'h0, 32'h0, 5'd5, 5'd6, 5'd7, 6'h20);
        tick();
        check("ld_rd1", bus.read_data1_EX, 32'h1234_5678);
        check("ld_valid", bus.valid_EX, 1'b1);

        // Stall: A held for three cycles while inputs change to B
        bus.stall = 1'b1;
        set_in(1'b1, 2'b01, 6'b001100, 32'hCAFE_0001, 32'h5, 32'h6, 5'd8, 5'd9, 5'd10, 6'h22);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rd1", bus.read_data1_EX, 32'h1234_5678);
        end
        bus.stall = 1'b0;
        tick();
        check("unstall_rd1", bus.read_data1_EX, 32'hCAFE_0001);

        // Flush wins over stall
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        set_in(1'b1, 2'b00, 6'b000010, 32'h9, 32'h9, 32'h9, 5'd1, 5'd1, 5'd1, 6'd1);
        tick();
        check("flush_memrd", bus.MemRead_EX, 1'b0);
        check("flush_cnt", bus.bubble_count, 4'd1);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // Hazard-mux bubble with live datapath
        set_in(1'b1, 2'b00, 6'b000000, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0, 5'd0, 6'd0);
        tick();
        check("haz_rd2", bus.read_data2_EX, 32'hDEAD_BEEF);
        check("haz_cnt", bus.bubble_count, 4'd2);

        // Saturation over twenty flushes
        bus.flush = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt", bus.bubble_count, 4'hF);
        bus.flush = 1'b0;

        // Reset mid-stream, then randomized traffic with occasional resets
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rand_in();
            bus.stall = ($urandom_range(0, 99) < 25);
            bus.flush = ($urandom_range(0, 99) < 8);
            rst       = ($urandom_range(0, 99) < 2);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_reg.md
# id_ex_pipeline_reg

ID/EX pipeline register for the five-stage MIPS core. It sits directly downstream of the ID-stage control bubble mux and captures that mux's gated control bits together with the ID datapath fields. It presents them to the EX stage, forwarding unit and hazard detection unit. It supports hold (stall), flush (bubble insertion) and a saturating bubble counter for CPI analysis.

## Interface
Parameters:
- DATA_W, 32, width of register-file read data and sign-extended immediate
- CNT_W, 16, width of bubble counter

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold all ID/EX contents this cycle
- flush  input  1  load a bubble this cycle (branch taken / exception)
- id_valid  input  1  ID stage holds a real instruction
- ALUOp  input  2  ALU operation class from control mux
- RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg  input  1 each  gated control bits from control mux
- read_data1, read_data2  input  DATA_W  register-file operands
- imm_ext  input  DATA_W  sign-extended immediate
- rs, rt, rd  input  5 each  register specifiers
- funct  input  6  instruction funct field
- ALUOp_EX  output  2  registered ALUOp
- RegDst_EX, RegWrite_EX, ALUSrc_EX, MemWrite_EX, MemRead_EX, MemtoReg_EX  output  1 each  registered control
- read_data1_EX, read_data2_EX, imm_ext_EX  output  DATA_W  registered datapath
- rs_EX, rt_EX, rd_EX  output  5 each  registered specifiers
- funct_EX  output  6  registered funct
- valid_EX  output  1  EX stage holds a real instruction
- bubble_count  output  CNT_W  number of bubbles loaded since reset

## Operation
- Per-edge priority: rst > flush > stall > normal load.
- rst: all outputs zero, bubble_count = 0.
- flush: all control outputs, valid_EX, and all datapath/specifier outputs forced to zero. bubble_count increments.
- stall (flush=0): every output holds its previous value. bubble_count unchanged.
- normal load (stall=0, flush=0): all outputs take their inputs; valid_EX = id_valid.
- If id_valid=0 on a normal load, the register loads a bubble:
  - control bits and valid_EX become zero regardless of input values; datapath fields still load.
  - bubble_count increments.
- A load where id_valid=1 but all control inputs are zero (hazard-mux bubble) counts as a bubble. It is detected as RegWrite|MemWrite|MemRead==0 and ALUOp==0. valid_EX is cleared in that case.
- bubble_count saturates at all-ones; it never wraps.
- No combinational path from any input to any output.

## Timing
- Latency: exactly one clock from input to output on normal load.
- stall asserted for N cycles holds outputs N cycles; the first edge after stall deasserts loads current inputs.
- flush and stall in the same cycle: flush wins, so a bubble is loaded.
- rst asserted mid-stream clears state at that edge. The first edge after rst deasserts performs a normal load.
- bubble_count updates on the same edge as the bubble load and is visible the next cycle.

## Test plan
- Reset: drive rst=1 for 2 cycles with nonzero inputs -> all outputs 0, bubble_count=0.
- Normal load: ALUOp=2'b10, RegDst=1, RegWrite=1, read_data1=32'h12345678, rs=5, rt=6, rd=7, id_valid=1 -> same values on *_EX one cycle later, valid_EX=1, bubble_count=0.
- Stall: after loading value A, hold stall=1 for 3 cycles while changing inputs to B -> outputs stay A for 3 cycles, become B one cycle after stall drops.
- Flush vs stall: assert flush=1 and stall=1 together with MemRead=1 -> next cycle MemRead_EX=0, valid_EX=0, read_data1_EX=0, bubble_count=1.
- Hazard bubble: id_valid=1, all control inputs 0, read_data2=32'hDEADBEEF -> RegWrite_EX=0, valid_EX=0, read_data2_EX=32'hDEADBEEF, bubble_count increments by 1.
- Saturation: CNT_W=4, 20 consecutive flushes -> bubble_count climbs to 4'hF and stays at 4'hF.
